axil_cmd_packer: RTL and testbench

- AXI4-Lite subordinate that serialises loads and stores into a packed command stream of format {write_not_read, addr field, data field} toward a narrow link.
- Returns read data from a response stream back onto the AXI R channel.
- Generalises the single-outstanding packer:
  - parametrised field widths;
  - independent AW/W acceptance;
  - concurrent read/write arbitration with no mutex requirement;
  - up to outstanding_els_p in-flight commands, with in-order responses;
  - SLVERR for unencodable addresses.

---
 rtl/axil_cmd_packer.sv | 204 ++++++++++++++++++++
 tb/tb_axil_cmd_packer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_packer.sv
// axil_cmd_packer
// AXI4-Lite subordinate that turns loads and stores into packed link commands
// {write_not_read, addr field, data field}. Read data comes back on the
// response stream and is returned on R. Responses are retired strictly in
// issue order, and up to outstanding_els_p commands may be in flight.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   s_axi_aw*/w*/b*           AXI4-Lite write address / data / response
//   s_axi_ar*/r*              AXI4-Lite read address / data
//   data_o, v_o, ready_i      packed command stream toward the link
//   data_i, v_i, ready_o      read response stream from the link
module axil_cmd_packer #(
  parameter int axi_addr_width_p   = 32,
  parameter int axi_data_width_p   = 32,
  parameter int addr_field_width_p = 23,
  parameter int data_field_width_p = 8,
  parameter int pkt_width_p        = 32,
  parameter int outstanding_els_p  = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [axi_addr_width_p-1:0]   s_axi_awaddr_i,
  input  logic [2:0]                    s_axi_awprot_i,
  input  logic                          s_axi_awvalid_i,
  output logic                          s_axi_awready_o,
  input  logic [axi_data_width_p-1:0]   s_axi_wdata_i,
  input  logic [axi_data_width_p/8-1:0] s_axi_wstrb_i,
  input  logic                          s_axi_wvalid_i,
  output logic                          s_axi_wready_o,
  output logic [1:0]                    s_axi_bresp_o,
  output logic                          s_axi_bvalid_o,
  input  logic                          s_axi_bready_i,
  input  logic [axi_addr_width_p-1:0]   s_axi_araddr_i,
  input  logic [2:0]                    s_axi_arprot_i,
  input  logic                          s_axi_arvalid_i,
  output logic                          s_axi_arready_o,
  output logic [axi_data_width_p-1:0]   s_axi_rdata_o,
  output logic [1:0]                    s_axi_rresp_o,
  output logic                          s_axi_rvalid_o,
  input  logic                          s_axi_rready_i,
  output logic [pkt_width_p-1:0]        data_o,
  output logic                          v_o,
  input  logic                          ready_i,
  input  logic [axi_data_width_p-1:0]   data_i,
  input  logic                          v_i,
  output logic                          ready_o
);

  localparam int ptr_w_lp = (outstanding_els_p > 1) ? $clog2(outstanding_els_p) : 1;
  localparam int cnt_w_lp = $clog2(outstanding_els_p) + 1;
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(outstanding_els_p - 1);
  localparam logic [cnt_w_lp-1:0] els_lp      = cnt_w_lp'(outstanding_els_p);

  if (pkt_width_p != 1 + addr_field_width_p + data_field_width_p) begin : g_bad_pkt_width
    $error("axil_cmd_packer: pkt_width_p must equal 1+addr_field_width_p+data_field_width_p");
  end

  // Holding registers, arbitration and order-FIFO state.
  logic                          live_r;
  logic                          aw_full_r, w_full_r, ar_full_r;
  logic [axi_addr_width_p-1:0]   aw_addr_r, ar_addr_r;
  logic [data_field_width_p-1:0] w_data_r;
  logic                          rr_read_r;
  logic                          lock_r, lock_read_r;
  logic [1:0]                    fifo_mem_r [outstanding_els_p];
  logic [ptr_w_lp-1:0]           wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0]           count_r;

  logic live_s, cand_w_s, cand_r_s, sel_read_s, legal_s, fifo_full_s;
  logic act_s, issue_s, retire_s, push_s, pop_s;
  logic head_v_s, head_read_s, head_err_s;
  logic aw_acc_s, w_acc_s, ar_acc_s;
  logic [axi_addr_width_p-1:0] sel_addr_s;
  logic unused_s;

  // The link partner shares this reset, so handshakes stay closed one cycle past it.
  assign live_s   = live_r & ~reset_i;
  assign unused_s = ^{s_axi_awprot_i, s_axi_arprot_i, s_axi_wstrb_i, s_axi_wdata_i};

  // Arbitration, range check and command issue.
  always_comb begin
    cand_w_s = aw_full_r & w_full_r;
    cand_r_s = ar_full_r;
    // A stalled command keeps its slot so data_o cannot change under v_o.
    if (lock_r) begin
      sel_read_s = lock_read_r;
    end else if (cand_w_s & cand_r_s) begin
      sel_read_s = rr_read_r;
    end else begin
      sel_read_s = cand_r_s;
    end
    sel_addr_s  = sel_read_s ? ar_addr_r : aw_addr_r;
    legal_s     = ((sel_addr_s >> addr_field_width_p) == {axi_addr_width_p{1'b0}});
    fifo_full_s = (count_r == els_lp);
    act_s       = live_s & (cand_w_s | cand_r_s) & ~fifo_full_s;
    v_o         = act_s & legal_s;
    retire_s    = act_s & ~legal_s;
    issue_s     = v_o & ready_i;
    push_s      = issue_s | retire_s;
    if (v_o) begin
      data_o = sel_read_s
             ? {1'b0, sel_addr_s[addr_field_width_p-1:0], {data_field_width_p{1'b0}}}
             : {1'b1, sel_addr_s[addr_field_width_p-1:0], w_data_r};
    end else begin
      data_o = {pkt_width_p{1'b0}};
    end
    s_axi_awready_o = live_s & ~aw_full_r;
    s_axi_wready_o  = live_s & ~w_full_r;
    s_axi_arready_o = live_s & ~ar_full_r;
    aw_acc_s = s_axi_awvalid_i & s_axi_awready_o;
    w_acc_s  = s_axi_wvalid_i & s_axi_wready_o;
    ar_acc_s = s_axi_arvalid_i & s_axi_arready_o;
  end

  // In-order response path driven by the order-FIFO head.
  always_comb begin
    head_v_s    = live_s & (count_r != {cnt_w_lp{1'b0}});
    head_read_s = fifo_mem_r[rd_ptr_r][1];
    head_err_s  = fifo_mem_r[rd_ptr_r][0];
    s_axi_bvalid_o = head_v_s & ~head_read_s;
    s_axi_bresp_o  = (s_axi_bvalid_o & head_err_s) ? 2'b10 : 2'b00;
    s_axi_rvalid_o = head_v_s & head_read_s & (head_err_s | v_i);
    s_axi_rresp_o  = (s_axi_rvalid_o & head_err_s) ? 2'b10 : 2'b00;
    if (s_axi_rvalid_o & ~head_err_s) begin
      s_axi_rdata_o = data_i;
    end else begin
      s_axi_rdata_o = {axi_data_width_p{1'b0}};
    end
    // Response data is only drawn while the head is a legal read.
    ready_o = head_v_s & head_read_s & ~head_err_s & s_axi_rready_i;
    pop_s   = (s_axi_bvalid_o & s_axi_bready_i) | (s_axi_rvalid_o & s_axi_rready_i);
  end

  // Holding registers, round-robin pointer and issue lock.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      live_r      <= 1'b0;
      aw_full_r   <= 1'b0;
      w_full_r    <= 1'b0;
      ar_full_r   <= 1'b0;
      aw_addr_r   <= {axi_addr_width_p{1'b0}};
      ar_addr_r   <= {axi_addr_width_p{1'b0}};
      w_data_r    <= {data_field_width_p{1'b0}};
      rr_read_r   <= 1'b1;
      lock_r      <= 1'b0;
      lock_read_r <= 1'b0;
    end else begin
      live_r <= 1'b1;
      if (aw_acc_s) begin
        aw_full_r <= 1'b1;
        aw_addr_r <= s_axi_awaddr_i;
      end else if (push_s & ~sel_read_s) begin
        aw_full_r <= 1'b0;
      end
      if (w_acc_s) begin
        w_full_r <= 1'b1;
        w_data_r <= s_axi_wdata_i[data_field_width_p-1:0];
      end else if (push_s & ~sel_read_s) begin
        w_full_r <= 1'b0;
      end
      if (ar_acc_s) begin
        ar_full_r <= 1'b1;
        ar_addr_r <= s_axi_araddr_i;
      end else if (push_s & sel_read_s) begin
        ar_full_r <= 1'b0;
      end
      if (push_s) begin
        rr_read_r <= ~rr_read_r;
      end
      lock_r      <= v_o & ~ready_i;
      lock_read_r <= sel_read_s;
    end
  end

  // Order-FIFO storage of {is_read, err} per retired-or-issued command.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {sel_read_s, retire_s};
    end
  end

  // Order-FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= {ptr_w_lp{1'b0}};
      rd_ptr_r <= {ptr_w_lp{1'b0}};
      count_r  <= {cnt_w_lp{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? {ptr_w_lp{1'b0}} : wr_ptr_r + ptr_w_lp'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? {ptr_w_lp{1'b0}} : rd_ptr_r + ptr_w_lp'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_packer.sv
// Directed self-checking bench for axil_cmd_packer. Inputs change on the
// falling edge; outputs are checked 1 time unit later, away from the rising edge.
module tb_axil_cmd_packer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] s_axi_awaddr_i, s_axi_wdata_i, s_axi_araddr_i, data_i;
  logic [2:0]  s_axi_awprot_i, s_axi_arprot_i;
  logic [3:0]  s_axi_wstrb_i;
  logic        s_axi_awvalid_i, s_axi_wvalid_i, s_axi_bready_i, s_axi_arvalid_i, s_axi_rready_i;
  logic        ready_i, v_i;
  logic        s_axi_awready_o, s_axi_wready_o, s_axi_bvalid_o, s_axi_arready_o, s_axi_rvalid_o;
  logic [1:0]  s_axi_bresp_o, s_axi_rresp_o;
  logic [31:0] s_axi_rdata_o, data_o;
  logic        v_o, ready_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit got_rdy;

  axil_cmd_packer #(
    .axi_addr_width_p(32), .axi_data_width_p(32), .addr_field_width_p(23),
    .data_field_width_p(8), .pkt_width_p(32), .outstanding_els_p(4)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .s_axi_awaddr_i(s_axi_awaddr_i), .s_axi_awprot_i(s_axi_awprot_i),
    .s_axi_awvalid_i(s_axi_awvalid_i), .s_axi_awready_o(s_axi_awready_o),
    .s_axi_wdata_i(s_axi_wdata_i), .s_axi_wstrb_i(s_axi_wstrb_i),
    .s_axi_wvalid_i(s_axi_wvalid_i), .s_axi_wready_o(s_axi_wready_o),
    .s_axi_bresp_o(s_axi_bresp_o), .s_axi_bvalid_o(s_axi_bvalid_o), .s_axi_bready_i(s_axi_bready_i),
    .s_axi_araddr_i(s_axi_araddr_i), .s_axi_arprot_i(s_axi_arprot_i),
    .s_axi_arvalid_i(s_axi_arvalid_i), .s_axi_arready_o(s_axi_arready_o),
    .s_axi_rdata_o(s_axi_rdata_o), .s_axi_rresp_o(s_axi_rresp_o),
    .s_axi_rvalid_o(s_axi_rvalid_o), .s_axi_rready_i(s_axi_rready_i),
    .data_o(data_o), .v_o(v_o), .ready_i(ready_i),
    .data_i(data_i), .v_i(v_i), .ready_o(ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    s_axi_awaddr_i = 32'h0; s_axi_wdata_i = 32'h0; s_axi_araddr_i = 32'h0; data_i = 32'h0;
    s_axi_awprot_i = 3'h0; s_axi_arprot_i = 3'h0; s_axi_wstrb_i = 4'hF;
    s_axi_awvalid_i = 1'b0; s_axi_wvalid_i = 1'b0; s_axi_arvalid_i = 1'b0;
    s_axi_bready_i = 1'b1; s_axi_rready_i = 1'b1; ready_i = 1'b1; v_i = 1'b0;

    // Reset and the cycle after it: everything closed.
    @(negedge clk_i); #1;
    chk_eq("rst_awready", s_axi_awready_o, 1'b0);
    chk_eq("rst_v_o", v_o, 1'b0);
    @(negedge clk_i); reset_i = 1'b0; #1;
    chk_eq("post_rst_awready", s_axi_awready_o, 1'b0);
    chk_eq("post_rst_arready", s_axi_arready_o, 1'b0);
    @(negedge clk_i); #1;
    chk_eq("open_awready", s_axi_awready_o, 1'b1);
    chk_eq("open_wready", s_axi_wready_o, 1'b1);

    // Single write.
    @(negedge clk_i);
    s_axi_awvalid_i = 1'b1; s_axi_awaddr_i = 32'h0000_0123;
    s_axi_wvalid_i = 1'b1; s_axi_wdata_i = 32'h0000_00A5;
    @(negedge clk_i); s_axi_awvalid_i = 1'b0; s_axi_wvalid_i = 1'b0; #1;
    chk_eq("wr_v_o", v_o, 1'b1);
    chk_eq("wr_data_o", data_o, 32'h8001_23A5);
    chk_eq("wr_awready_full", s_axi_awready_o, 1'b0);
    chk_eq("wr_bvalid_early", s_axi_bvalid_o, 1'b0);
    @(negedge clk_i); #1;
    chk_eq("wr_v_o_done", v_o, 1'b0);
    chk_eq("wr_bvalid", s_axi_bvalid_o, 1'b1);
    chk_eq("wr_bresp", s_axi_bresp_o, 2'd0);
    chk_eq("wr_ready_o_head_wr", ready_o, 1'b0);
    @(negedge clk_i); #1;
    chk_eq("wr_bvalid_popped", s_axi_bvalid_o, 1'b0);

    // Single read, data returned a few cycles later.
    @(negedge clk_i); s_axi_arvalid_i = 1'b1; s_axi_araddr_i = 32'h0000_0040;
    @(negedge clk_i); s_axi_arvalid_i = 1'b0; #1;
    chk_eq("rd_v_o", v_o, 1'b1);
    chk_eq("rd_data_o", data_o, 32'h0000_4000);
    @(negedge clk_i); #1;
    chk_eq("rd_rvalid_wait", s_axi_rvalid_o, 1'b0);
    chk_eq("rd_ready_o", ready_o, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i); v_i = 1'b1; data_i = 32'h0000_005C; #1;
    chk_eq("rd_rvalid", s_axi_rvalid_o, 1'b1);
    chk_eq("rd_rdata", s_axi_rdata_o, 32'h0000_005C);
    chk_eq("rd_rresp", s_axi_rresp_o, 2'd0);
    @(negedge clk_i); v_i = 1'b0; #1;
    chk_eq("rd_rvalid_popped", s_axi_rvalid_o, 1'b0);
    chk_eq("rd_ready_o_empty", ready_o, 1'b0);

    // W two cycles ahead of AW, AR alongside AW; pointer now favours read.
    @(negedge clk_i); s_axi_wvalid_i = 1'b1; s_axi_wdata_i = 32'h0000_0011;
    @(negedge clk_i); s_axi_wvalid_i = 1'b0; #1;
    chk_eq("mix_wready_full", s_axi_wready_o, 1'b0);
    chk_eq("mix_no_issue", v_o, 1'b0);
    @(negedge clk_i);
    s_axi_awvalid_i = 1'b1; s_axi_awaddr_i = 32'h0000_0300;
    s_axi_arvalid_i = 1'b1; s_axi_araddr_i = 32'h0000_0200;
    @(negedge clk_i); s_axi_awvalid_i = 1'b0; s_axi_arvalid_i = 1'b0; #1;
    chk_eq("mix_first_rd", data_o, 32'h0002_0000);
    @(negedge clk_i); #1;
    chk_eq("mix_second_v", v_o, 1'b1);
    chk_eq("mix_second_wr", data_o, 32'h8003_0011);
    @(negedge clk_i); #1;
    chk_eq("mix_bvalid_blocked", s_axi_bvalid_o, 1'b0);
    v_i = 1'b1; data_i = 32'h0000_0077; #1;
    chk_eq("mix_rdata", s_axi_rdata_o, 32'h0000_0077);
    @(negedge clk_i); data_i = 32'h0000_0099; #1;
    chk_eq("mix_bvalid", s_axi_bvalid_o, 1'b1);
    chk_eq("mix_vi_held_off", ready_o, 1'b0);
    chk_eq("mix_rvalid_off", s_axi_rvalid_o, 1'b0);
    @(negedge clk_i); v_i = 1'b0; #1;
    chk_eq("mix_drained", s_axi_bvalid_o, 1'b0);

    // Five reads with no responses: only four may be in flight.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i); s_axi_arvalid_i = 1'b1; s_axi_araddr_i = 32'(k * 16);
      got_rdy = 1'b0;
      for (int c = 0; c < 20; c++) begin
        #1;
        if (s_axi_arready_o) begin
          got_rdy = 1'b1;
          break;
        end
        @(negedge clk_i);
      end
      chk_eq("full_arready_wait", got_rdy, 1'b1);
      @(posedge clk_i);
    end
    @(negedge clk_i); s_axi_arvalid_i = 1'b0; #1;
    chk_eq("full_no_issue", v_o, 1'b0);
    chk_eq("full_arready", s_axi_arready_o, 1'b0);
    repeat (2) @(negedge clk_i);
    #1;
    chk_eq("full_still_held", v_o, 1'b0);
    chk_eq("full_arready_held", s_axi_arready_o, 1'b0);
    @(negedge clk_i); v_i = 1'b1; data_i = 32'h0000_00AA; #1;
    chk_eq("full_first_rdata", s_axi_rdata_o, 32'h0000_00AA);
    @(negedge clk_i); v_i = 1'b0; #1;
    chk_eq("full_fifth_v", v_o, 1'b1);
    chk_eq("full_fifth_data", data_o, 32'h0000_5000);
    @(negedge clk_i); #1;
    chk_eq("full_arready_back", s_axi_arready_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); v_i = 1'b1; data_i = 32'(8'hB0 + k); #1;
      chk_eq("full_drain_rvalid", s_axi_rvalid_o, 1'b1);
      chk_eq("full_drain_rdata", s_axi_rdata_o, 32'(8'hB0 + k));
    end
    @(negedge clk_i); #1;
    chk_eq("full_empty_rvalid", s_axi_rvalid_o, 1'b0);
    v_i = 1'b0;

    // Out-of-range write then read, with ready_i low.
    @(negedge clk_i); ready_i = 1'b0;
    s_axi_awvalid_i = 1'b1; s_axi_awaddr_i = 32'h0080_0000;
    s_axi_wvalid_i = 1'b1; s_axi_wdata_i = 32'h0000_0033;
    @(negedge clk_i); s_axi_awvalid_i = 1'b0; s_axi_wvalid_i = 1'b0; #1;
    chk_eq("err_wr_no_v", v_o, 1'b0);
    @(negedge clk_i); #1;
    chk_eq("err_bvalid", s_axi_bvalid_o, 1'b1);
    chk_eq("err_bresp", s_axi_bresp_o, 2'd2);
    chk_eq("err_awready", s_axi_awready_o, 1'b1);
    @(negedge clk_i); s_axi_arvalid_i = 1'b1; s_axi_araddr_i = 32'h0080_0000;
    @(negedge clk_i); s_axi_arvalid_i = 1'b0; #1;
    chk_eq("err_rd_no_v", v_o, 1'b0);
    @(negedge clk_i); #1;
    chk_eq("err_rvalid", s_axi_rvalid_o, 1'b1);
    chk_eq("err_rdata", s_axi_rdata_o, 32'h0);
    chk_eq("err_rresp", s_axi_rresp_o, 2'd2);
    chk_eq("err_ready_o", ready_o, 1'b0);
    @(negedge clk_i); #1;
    chk_eq("err_rvalid_popped", s_axi_rvalid_o, 1'b0);

    // Stalled read must hold data_o while a write becomes a competitor.
    s_axi_bready_i = 1'b0;
    @(negedge clk_i); s_axi_arvalid_i = 1'b1; s_axi_araddr_i = 32'h0000_0078;
    @(negedge clk_i); s_axi_arvalid_i = 1'b0;
    s_axi_awvalid_i = 1'b1; s_axi_awaddr_i = 32'h0000_0456;
    s_axi_wvalid_i = 1'b1; s_axi_wdata_i = 32'h0000_005A; #1;
    chk_eq("stall_v0", v_o, 1'b1);
    chk_eq("stall_d0", data_o, 32'h0000_7800);
    @(negedge clk_i); s_axi_awvalid_i = 1'b0; s_axi_wvalid_i = 1'b0; #1;
    chk_eq("stall_d1", data_o, 32'h0000_7800);
    @(negedge clk_i); #1;
    chk_eq("stall_d2", data_o, 32'h0000_7800);
    chk_eq("stall_v2", v_o, 1'b1);
    ready_i = 1'b1;
    @(negedge clk_i); #1;
    chk_eq("stall_wr_after", data_o, 32'h8004_565A);
    @(negedge clk_i); #1;
    chk_eq("stall_rd_pending", s_axi_rvalid_o, 1'b0);
    chk_eq("stall_ready_o_rd_head", ready_o, 1'b1);

    // Reset with two commands outstanding.
    reset_i = 1'b1; #1;
    chk_eq("mrst_ready_o", ready_o, 1'b0);
    chk_eq("mrst_awready", s_axi_awready_o, 1'b0);
    @(negedge clk_i); reset_i = 1'b0; v_i = 1'b1; s_axi_bready_i = 1'b1; #1;
    chk_eq("mrst_after_rvalid", s_axi_rvalid_o, 1'b0);
    chk_eq("mrst_after_bvalid", s_axi_bvalid_o, 1'b0);
    chk_eq("mrst_after_v_o", v_o, 1'b0);
    chk_eq("mrst_after_awready", s_axi_awready_o, 1'b0);
    @(negedge clk_i); #1;
    chk_eq("mrst_empty_rvalid", s_axi_rvalid_o, 1'b0);
    chk_eq("mrst_empty_ready_o", ready_o, 1'b0);
    chk_eq("mrst_awready_open", s_axi_awready_o, 1'b1);
    v_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
